// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: drives the instruction-memory address, captures
// {address, instruction} pairs into a prefetch FIFO and hands them to decode.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef IMEM_DEPTH
`define IMEM_DEPTH 256
`endif

module imem_fetch_ctrl #(
    parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int IMEM_DEPTH = `IMEM_DEPTH,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_addr,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [WORD_WIDTH-1:0]         imem_inst,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_WIDTH-1:0]         out_inst,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] LP_RESET_ADDR = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR  = ADDR_WIDTH'(IMEM_DEPTH - 1);
    // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH_EXT  = (ADDR_WIDTH + 1)'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0]      LP_FULL_CNT   = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] r_mem_inst [FIFO_DEPTH];

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_fetch_ptr;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic [ADDR_WIDTH-1:0] w_redirect_target;

    assign w_full  = (r_count == LP_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & out_ready;
    // A pop frees the slot this same edge, so a full FIFO still accepts a push.
    assign w_push  = fetch_en & ~redirect_valid & (~w_full | w_pop);

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        w_ptr_next        = r_fetch_ptr + ADDR_WIDTH'(1);
        w_redirect_target = redirect_addr;
        if (r_fetch_ptr == LP_LAST_ADDR) begin
            w_ptr_next = '0;
        end
        if ({1'b0, redirect_addr} >= LP_DEPTH_EXT) begin
            w_redirect_target = '0;
        end
    end

    // NOTE: the storage array carries no reset; stale contents are never observed
    // because the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_tail] <= r_fetch_ptr;
            r_mem_inst[r_tail] <= imem_inst;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_fetch_ptr <= LP_RESET_ADDR;
        end else if (redirect_valid) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_fetch_ptr <= w_redirect_target;
        end else begin
            if (w_push) begin
                r_tail      <= r_tail + PTR_W'(1);
                r_fetch_ptr <= w_ptr_next;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_addr  = r_fetch_ptr;
    assign out_valid  = ~w_empty;
    assign out_inst   = w_empty ? '0 : r_mem_inst[r_head];
    assign out_addr   = w_empty ? '0 : r_mem_addr[r_head];
    assign fifo_count = r_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: streaming, back-pressure, redirects,
// address wrap/clamp and asynchronous reset with a full FIFO.

module tb_imem_fetch_ctrl;

    localparam int AW    = 8;
    localparam int WW    = 32;
    localparam int DEPTH = 48;
    localparam int FD    = 4;

    logic          clk;
    logic          rst_n;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic [AW-1:0] imem_addr;
    logic [WW-1:0] imem_inst;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_inst;
    logic [AW-1:0] out_addr;
    logic [$clog2(FD):0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    imem_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .IMEM_DEPTH (DEPTH),
        .FIFO_DEPTH (FD),
        .RESET_ADDR (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_addr       (out_addr),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k of the memory holds a tagged copy of k so address/instruction mix-ups show.
    function automatic logic [WW-1:0] inst_of(input int a);
        return 32'hC0DE_0000 + 32'(a);
    endfunction

    assign imem_inst = inst_of(int'(imem_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wrap_exp [4];
        wrap_exp = '{46, 47, 0, 1};

        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;

        // Reset state
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_addr",  32'(out_addr), 0);
        check("rst_inst",  out_inst, 0);
        check("rst_imem",  32'(imem_addr), 0);

        // Streaming from reset, one per cycle
        rst_n = 1'b1;
        check("s_imem0", 32'(imem_addr), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("s_valid", 32'(out_valid), 1);
            check("s_addr",  32'(out_addr), 32'(k));
            check("s_inst",  out_inst, inst_of(k));
            check("s_count", 32'(fifo_count), 1);
        end

        // Back-pressure from reset: fill to 4, pointer stalls at 4
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) begin
            step();
            check("bp_head", 32'(out_addr), 0);
        end
        check("bp_count", 32'(fifo_count), 4);
        check("bp_imem",  32'(imem_addr), 4);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("bp_addr",  32'(out_addr), 32'(k));
            check("bp_inst",  out_inst, inst_of(k));
            check("bp_count_full", 32'(fifo_count), 4);
            step();
        end

        // Drain one entry with fetch off, leaving 3 entries
        fetch_en = 1'b0;
        step();
        check("d_count", 32'(fifo_count), 3);
        check("d_addr",  32'(out_addr), 7);
        check("d_imem",  32'(imem_addr), 10);

        // Redirect to 0x20 with 3 entries held
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        fetch_en       = 1'b1;
        out_ready      = 1'b0;
        step();
        check("r_valid", 32'(out_valid), 0);
        check("r_count", 32'(fifo_count), 0);
        check("r_imem",  32'(imem_addr), 32'h20);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        check("r_valid2", 32'(out_valid), 1);
        check("r_addr0",  32'(out_addr), 32'h20);
        check("r_inst0",  out_inst, inst_of(32'h20));
        step();
        check("r_addr1",  32'(out_addr), 32'h21);

        // Redirect coincident with a pop, fetch_en low
        check("rp_pre_valid", 32'(out_valid), 1);
        redirect_valid = 1'b1;
        redirect_addr  = 8'd5;
        fetch_en       = 1'b0;
        step();
        check("rp_count", 32'(fifo_count), 0);
        check("rp_valid", 32'(out_valid), 0);
        check("rp_imem",  32'(imem_addr), 5);
        redirect_valid = 1'b0;
        repeat (3) begin
            step();
            check("rp_idle_valid", 32'(out_valid), 0);
            check("rp_idle_imem",  32'(imem_addr), 5);
        end
        fetch_en = 1'b1;
        step();
        check("rp_addr5", 32'(out_addr), 5);
        step();
        check("rp_addr6", 32'(out_addr), 6);

        // Pointer wrap past IMEM_DEPTH-1
        redirect_valid = 1'b1;
        redirect_addr  = 8'(DEPTH - 2);
        step();
        check("w_valid", 32'(out_valid), 0);
        check("w_imem",  32'(imem_addr), 32'(DEPTH - 2));
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("w_addr", 32'(out_addr), 32'(wrap_exp[k]));
            check("w_inst", out_inst, inst_of(wrap_exp[k]));
        end

        // Out-of-range redirect clamps to 0
        redirect_valid = 1'b1;
        redirect_addr  = 8'(DEPTH);
        step();
        check("c_imem",  32'(imem_addr), 0);
        check("c_count", 32'(fifo_count), 0);
        redirect_valid = 1'b0;
        step();
        check("c_addr", 32'(out_addr), 0);
        check("c_inst", out_inst, inst_of(0));

        // Asynchronous reset with a full FIFO
        out_ready = 1'b0;
        repeat (5) step();
        check("ar_full",  32'(fifo_count), 4);
        check("ar_valid_pre", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_inst",  out_inst, 0);
        check("ar_addr",  32'(out_addr), 0);
        check("ar_count", 32'(fifo_count), 0);
        check("ar_imem",  32'(imem_addr), 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("ar_imem_rel", 32'(imem_addr), 0);
        step();
        check("ar_re_addr0", 32'(out_addr), 0);
        check("ar_re_valid", 32'(out_valid), 1);
        step();
        check("ar_re_addr1", 32'(out_addr), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the instruction memory for the core.
- Owns the fetch pointer and drives the memory's word address; the memory returns the instruction combinationally in the same cycle.
- Captures {address, instruction} pairs into a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump/trap) by flushing the FIFO and restarting fetch at the new address.

Parameters:
- ADDR_WIDTH, `MEM_ADDR_WIDTH: word-address width of the instruction memory.
- WORD_WIDTH, `WORD_WIDTH: instruction width.
- IMEM_DEPTH, `IMEM_DEPTH: number of instruction words; the fetch pointer wraps past IMEM_DEPTH-1.
- FIFO_DEPTH, 4: prefetch entries; power of two, minimum 2.
- RESET_ADDR, 0: word address fetched first after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_en  input  1  enables new fetches; when low, the FIFO still drains.
- redirect_valid  input  1  one-cycle pulse to flush and restart fetch.
- redirect_addr  input  ADDR_WIDTH  restart word address.
- imem_addr  output  ADDR_WIDTH  address to instruction memory; equals the fetch pointer, combinational.
- imem_inst  input  WORD_WIDTH  instruction returned by the memory in the same cycle.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts the head.
- out_inst  output  WORD_WIDTH  head instruction.
- out_addr  output  ADDR_WIDTH  head word address.
- fifo_count  output  log2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetch_ptr=RESET_ADDR; FIFO empty.
  - out_valid=0, out_inst=0, out_addr=0, fifo_count=0.
  - imem_addr=RESET_ADDR throughout reset.
  - Reset asserted mid-operation discards all entries immediately.
- Definitions:
  - pop = out_valid & out_ready.
  - push = fetch_en & ~redirect_valid & (count<FIFO_DEPTH | pop).
- On push:
  - Write {fetch_ptr, imem_inst} at the tail.
  - fetch_ptr <= (fetch_ptr==IMEM_DEPTH-1) ? 0 : fetch_ptr+1.
- On pop: advance the head.
  - Simultaneous push and pop keeps count unchanged and is legal when full.
- Redirect (highest priority):
  - Next edge: FIFO cleared (count=0), fetch_ptr <= redirect_addr.
  - No push that cycle; any coincident pop is discarded with the flush.
- Redirect address range: redirect_addr ≥ IMEM_DEPTH is clamped to 0.
- fetch_en low: fetch_ptr holds and no push occurs; pops continue normally.
- Outputs are read from FIFO storage (registered), never from imem_inst directly:
  - out_valid = (count!=0).
  - out_inst/out_addr = head entry; they hold stable while out_valid & ~out_ready.
- Latency:
  - Fetch of address A in cycle t → visible at out_* in cycle t+1.
  - Redirect pulse in cycle t → out_valid=0 in t+1; redirect target visible in t+2.
  - First instruction after reset release is visible 1 cycle after the first enabled edge.
- Throughput: 1 instruction/cycle sustained when out_ready=1.
- Full and no pop: the fetch pointer stalls and imem_addr holds; no instruction is skipped or duplicated.
- Pointer arithmetic: head/tail pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH or underflows.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, memory word k = k:
  - out_addr/out_inst stream 0,1,2,… one per cycle, first at cycle 1.
  - out_valid stays 1 continuously.
- out_ready=0 for 10 cycles:
  - fifo_count reaches 4; imem_addr holds at 4; head stays addr 0.
  - Raise out_ready: sequence continues 0,1,2,3,4,5 with no gap or duplicate.
- Redirect pulse to 0x20 while the FIFO holds 3 entries:
  - Next cycle out_valid=0, fifo_count=0.
  - Following cycle out_addr=0x20, then 0x21.
- Redirect coincident with a pop, and redirect with fetch_en=0:
  - Popped entry is dropped; FIFO empty.
  - fetch_ptr=target but no fetch until fetch_en returns.
- fetch_ptr at IMEM_DEPTH-2 with out_ready=1:
  - Addresses IMEM_DEPTH-2, IMEM_DEPTH-1, 0, 1.
  - redirect_addr=IMEM_DEPTH is clamped to 0.
- Assert rst_n low mid-stream with a full FIFO:
  - out_valid, out_inst, out_addr and fifo_count drop to 0 asynchronously, before the next clk edge; imem_addr=RESET_ADDR.
  - After release, the stream restarts at RESET_ADDR.
